if_fetch_unit: RTL



---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/if_fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and defaults for the RISC-V pipeline slice.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC generation, imem req/gnt/rvalid handshake, response buffering.
//   state | meaning
//   BOOT  | one idle cycle after reset
//   RUN   | issuing requests, accepting responses
//   FLUSH | discarding stale responses left over from a redirect
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] fetch_pc, pc_n;
  logic [CW-1:0]   outstanding, out_next;
  logic [CW-1:0]   drop_cnt, drop_n;
  logic [CW-1:0]   fifo_count, pend_count;
  logic [CW:0]     in_use;
  logic            grant, resp_keep, fifo_empty, fifo_full, pend_empty, pend_full;
  fetch_entry_t    fifo_head, fifo_wdata, pend_head, pend_wdata;
  logic            unused_pend;

  assign grant    = imem_req_o & imem_gnt_i;
  assign out_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);
  assign in_use   = {1'b0, outstanding} + {1'b0, fifo_count};

  // Only issue when a buffer slot is already reserved for the response.
  assign imem_req_o  = (state == RUN) & ~redirect_i & (in_use < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;

  assign resp_keep  = imem_rvalid_i & (drop_cnt == '0) & ~redirect_i;
  assign pend_wdata = '{pc: fetch_pc, inst: '0};
  assign fifo_wdata = '{pc: pend_head.pc, inst: imem_rdata_i};

  assign if_valid = ~fifo_empty & ~redirect_i;
  assign if_pc    = if_valid ? fifo_head.pc : '0;
  assign if_inst  = if_valid ? fifo_head.inst : NOP_INST;

  assign unused_pend = ^{pend_head.inst, pend_count, pend_empty, pend_full, fifo_full};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_keep),
    .wdata (fifo_wdata),
    .pop   (if_valid & ~stall_i),
    .flush (redirect_i),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Addresses of in-flight requests, retired in order as responses arrive.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pend_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .wdata (pend_wdata),
    .pop   (resp_keep),
    .flush (redirect_i),
    .rdata (pend_head),
    .count (pend_count),
    .empty (pend_empty),
    .full  (pend_full)
  );

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    drop_n  = drop_cnt;
    if (redirect_i) begin
      // Every request still in flight after this cycle belongs to the old stream.
      pc_n    = {redirect_pc_i[XLEN-1:2], 2'b00};
      drop_n  = out_next;
      state_n = (out_next != '0) ? FLUSH : RUN;
    end else begin
      if (grant) pc_n = fetch_pc + 32'd4;
      if (imem_rvalid_i && (drop_cnt != '0)) drop_n = drop_cnt - CW'(1);
      case (state)
        BOOT:    state_n = RUN;
        FLUSH:   if (drop_n == '0) state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= pc_n;
      outstanding <= out_next;
      drop_cnt    <= drop_n;
    end
  end
endmodule
